daq_readout_buffer: RTL
=======================

DAQ_READOUT_BUFFER -- requirements
Module: daq_readout_buffer

Interface
REQ-001 Parameter MAX_WORDS, default 1023: truncation threshold in 32-bit words per readout; legal range 1..1023.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 wr_data  in  32  readout word from front-end formatter.
REQ-005 wr_valid  in  1  wr_data valid.
REQ-006 wr_last  in  1  marks final word of a readout; qualified by wr_valid.
REQ-007 wr_ready  out  1  word accepted when wr_valid && wr_ready.
REQ-008 nreadouts_available  out  9  count of committed, unreleased buffers (0..64).
REQ-009 r_buf_id  out  6  id of oldest committed buffer (tail).
REQ-010 pick_buf_id  in  6  buffer selected by DMA stage for length and data reads.
REQ-011 buf_len  out  10  stored length in 32-bit words of buffer pick_buf_id.
REQ-012 r_ptr  in  10  32-bit word offset within picked buffer; always even.
REQ-013 data_from_buffer  out  64  {word r_ptr+1, word r_ptr} of picked buffer.
REQ-014 done_with_buffer  in  1  one-cycle pulse releasing the tail buffer.
REQ-015 trunc_count  out  16  saturating count of truncated readouts.
REQ-016 release_err  out  1  sticky flag: release requested while empty.

Function
REQ-017 Storage: 64 buffers x 1024 words, two 32-bit RAM banks (even/odd word), read address {pick_buf_id, r_ptr[9:1]}; length table 64 x 10 bits.
REQ-018 Write FSM states: IDLE (no readout open), FILL (words landing), DRAIN (truncated, discarding to wr_last).
REQ-019 IDLE -> FILL on first accepted word without wr_last; IDLE with accepted wr_last commits length 1 and stays IDLE.
REQ-020 FILL: word k written at offset k of head buffer; word counter increments per accepted word.
REQ-021 FILL: accepted wr_last commits length = words written including last word, then -> IDLE.
REQ-022 FILL: when counter reaches MAX_WORDS without wr_last, -> DRAIN; further words discarded with wr_ready high.
REQ-023 DRAIN: accepted wr_last commits length MAX_WORDS, increments trunc_count (saturates at 16'hFFFF), -> IDLE.
REQ-024 Commit: length written to table at head id, head id +1 mod 64, nreadouts_available +1.
REQ-025 wr_ready = 0 in IDLE while nreadouts_available == 64; otherwise 1 (open readout always owns a free buffer).
REQ-026 done_with_buffer with nreadouts_available > 0: r_buf_id +1 mod 64, count -1; with count == 0: ignored, release_err set.
REQ-027 Commit and release in same cycle: count unchanged, both pointers advance.
REQ-028 A buffer becomes visible in nreadouts_available on the cycle after its commit edge; its length and data are readable by then.
REQ-029 buf_len registered: reflects pick_buf_id one cycle after it changes.
REQ-030 data_from_buffer: two-cycle latency from r_ptr/pick_buf_id (RAM read plus output register); r_ptr[0] ignored.
REQ-031 Contents of a released buffer are undefined; reading an uncommitted buffer returns undefined data, no side effects.

Reset
REQ-032 On reset: write FSM IDLE, head and r_buf_id 0, nreadouts_available 0, trunc_count 0, release_err 0, wr_ready 1, buf_len 0, data_from_buffer 0; an open readout is discarded; RAM contents not cleared.

Verification
REQ-033 Readout of 5 words 0x100..0x104, wr_last on 5th -> nreadouts_available 1, buf_len 5 at pick 0; r_ptr 0/2/4 -> 64'h00000101_00000100, 64'h00000103_00000102, upper half don't-care with low 0x104.
REQ-034 Single-word readout (wr_last on first word) -> buf_len 1, count 1, head 1.
REQ-035 Commit 64 one-word readouts, no releases -> count 64, wr_ready 0; one done_with_buffer -> count 63, r_buf_id 1, wr_ready 1 next cycle.
REQ-036 1100-word readout with MAX_WORDS 1023 -> buf_len 1023, trunc_count 1, wr_ready high throughout, next readout lands in buffer 1.
REQ-037 Commit coinciding with done_with_buffer at count 3 -> count stays 3, r_buf_id and head both +1; done_with_buffer at count 0 -> release_err 1, count 0.
REQ-038 Reset asserted mid-readout after 10 words -> count 0, head 0, next readout commits to buffer 0 with correct length.

Source files
------------

// File: rtl/daq_readout_buffer.sv
// Readout buffer for the DAQ path: a ring of 64 committed readouts with per-buffer length table,
// truncation to MAX_WORDS, and a dual-bank (even/odd word) store read 64 bits at a time.
module daq_readout_buffer #(
  parameter int unsigned MAX_WORDS = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic [8:0]  nreadouts_available,
  output logic [5:0]  r_buf_id,
  input  logic [5:0]  pick_buf_id,
  output logic [9:0]  buf_len,
  input  logic [9:0]  r_ptr,
  output logic [63:0] data_from_buffer,
  input  logic        done_with_buffer,
  output logic [15:0] trunc_count,
  output logic        release_err
);

  typedef enum logic [1:0] {StIdle, StFill, StDrain} wr_state_e;

  localparam logic [9:0] MaxLen  = 10'(MAX_WORDS);
  localparam logic [8:0] NumBufs = 9'd64;

  wr_state_e   state_q, state_d;
  logic [9:0]  wcnt_q, wcnt_d;
  logic [5:0]  head_q, head_d;
  logic [5:0]  tail_q, tail_d;
  logic [8:0]  count_q, count_d;
  logic [15:0] trunc_q, trunc_d;
  logic        err_q, err_d;
  logic        wr_ready_q, wr_ready_d;
  logic [9:0]  buf_len_q;
  logic [63:0] data_q;

  logic        accept, commit, release_ok, wr_en, trunc_inc;
  logic [9:0]  wcnt_inc, commit_len;
  logic [14:0] wr_addr, rd_addr;

  logic [31:0] ram_even [32768];
  logic [31:0] ram_odd  [32768];
  logic [9:0]  len_tab  [64];
  logic [31:0] rd_even_q, rd_odd_q;

  always_comb begin
    accept     = wr_valid && wr_ready_q;
    wcnt_inc   = wcnt_q + 10'd1;
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    commit     = 1'b0;
    commit_len = wcnt_inc;
    wr_en      = 1'b0;
    trunc_inc  = 1'b0;
    if (accept) begin
      unique case (state_q)
        StIdle, StFill: begin
          wr_en = 1'b1;
          if (wr_last) begin
            commit  = 1'b1;
            state_d = StIdle;
            wcnt_d  = '0;
          end else if (wcnt_inc == MaxLen) begin
            state_d = StDrain;
            wcnt_d  = wcnt_inc;
          end else begin
            state_d = StFill;
            wcnt_d  = wcnt_inc;
          end
        end
        StDrain: begin
          if (wr_last) begin
            commit     = 1'b1;
            commit_len = MaxLen;
            trunc_inc  = 1'b1;
            state_d    = StIdle;
            wcnt_d     = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    release_ok = done_with_buffer && (count_q != 9'd0);
    head_d     = commit ? head_q + 6'd1 : head_q;
    tail_d     = release_ok ? tail_q + 6'd1 : tail_q;
    unique case ({commit, release_ok})
      2'b10:   count_d = count_q + 9'd1;
      2'b01:   count_d = count_q - 9'd1;
      default: count_d = count_q;
    endcase
    trunc_d = (trunc_inc && trunc_q != 16'hFFFF) ? trunc_q + 16'd1 : trunc_q;
    err_d   = err_q | (done_with_buffer && count_q == 9'd0);
    // An open readout already owns the head buffer, so only a new readout can be blocked.
    wr_ready_d = !((state_d == StIdle) && (count_d == NumBufs));

    wr_addr = {head_q, wcnt_q[9:1]};
    rd_addr = {pick_buf_id, r_ptr[9:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      trunc_q    <= '0;
      err_q      <= 1'b0;
      wr_ready_q <= 1'b1;
      buf_len_q  <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      trunc_q    <= trunc_d;
      err_q      <= err_d;
      wr_ready_q <= wr_ready_d;
      buf_len_q  <= len_tab[pick_buf_id];
      data_q     <= {rd_odd_q, rd_even_q};
    end
  end

  // Storage is not reset; validity is tracked only by the head/tail pointers.
  always_ff @(posedge clk) begin
    if (!reset && wr_en && !wcnt_q[0]) ram_even[wr_addr] <= wr_data;
    if (!reset && wr_en && wcnt_q[0])  ram_odd[wr_addr]  <= wr_data;
    if (!reset && commit)              len_tab[head_q]   <= commit_len;
    rd_even_q <= ram_even[rd_addr];
    rd_odd_q  <= ram_odd[rd_addr];
  end

  assign wr_ready            = wr_ready_q;
  assign nreadouts_available = count_q;
  assign r_buf_id            = tail_q;
  assign buf_len             = buf_len_q;
  assign data_from_buffer    = data_q;
  assign trunc_count         = trunc_q;
  assign release_err         = err_q;

endmodule
